bram_sched: RTL

BRAM_SCHED -- requirements
Module: bram_sched

---
 rtl/bram_sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/bram_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_sched_pkg
// Description : Shared BRAM parameters - FSM encoding, requester indices and
//               scheduler defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_sched_pkg;

    localparam int c_nreq_default    = 6;
    localparam int c_timeout_default = 64;

    localparam int c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_state_w-1:0] c_st_issue = 2'd1;
    localparam logic [c_state_w-1:0] c_st_wait  = 2'd2;
    localparam logic [c_state_w-1:0] c_st_done  = 2'd3;

    // Requester bit positions; all indices at or above input_read are reads.
    localparam int c_idx_input_write    = 0;
    localparam int c_idx_template_write = 1;
    localparam int c_idx_ff_write       = 2;
    localparam int c_idx_input_read     = 3;
    localparam int c_idx_template_read  = 4;
    localparam int c_idx_ff_read        = 5;

endpackage : bram_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; search starts one past ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 6,
    parameter int PTR_W = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx
);

    int               w_cand;
    logic [PTR_W-1:0] w_sel;
    logic             w_found;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        w_sel   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = (int'(ptr) + i) % NREQ;
            w_sel  = PTR_W'(w_cand);
            if (!w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                idx          = w_sel;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bram_sched.sv
`default_nettype none
// ============================================================================
// Module      : bram_sched
// Description : Round-robin scheduler serialising six requesters onto a
//               single BRAM controller, with READY timeout and sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_sched
    import bram_sched_pkg::*;
#(
    parameter int NREQ    = c_nreq_default,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    input  logic [127:0]   wr_data_0,
    input  logic [127:0]   wr_data_1,
    input  logic [1:0]     template_sel,
    output logic           input_write,
    output logic           template_write,
    output logic           ff_write,
    output logic           input_read,
    output logic           template_read,
    output logic           ff_read,
    output logic [127:0]   ctrl_wdata_0,
    output logic [127:0]   ctrl_wdata_1,
    output logic [1:0]     template_bits,
    input  logic [127:0]   read_data_0,
    input  logic           ready,
    input  logic           template_change,
    output logic [127:0]   rd_data,
    output logic           err,
    output logic           busy
);

    localparam int c_ptr_w = $clog2(NREQ);
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_init = c_ptr_w'(NREQ - 1);
    localparam logic [c_ptr_w-1:0] c_first_rd = c_ptr_w'(c_idx_input_read);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;

    logic [NREQ-1:0]    r_grant;
    logic [c_ptr_w-1:0] r_win;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [127:0]       r_ctrl_wdata_0;
    logic [127:0]       r_ctrl_wdata_1;
    logic [1:0]         r_template_bits;
    logic [127:0]       r_rd_data;
    logic               r_err;

    logic [NREQ-1:0]    w_arb_grant;
    logic [c_ptr_w-1:0] w_arb_idx;
    logic [NREQ-1:0]    w_strobe;
    logic               w_req_any;
    logic               w_timeout;
    logic               w_is_read;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (c_ptr_w)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx)
    );

    assign w_req_any = |req;
    assign w_timeout = (r_cnt >= c_cnt_last);
    assign w_is_read = (r_win >= c_first_rd);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_req_any) w_next_state = c_st_issue;
            c_st_issue: w_next_state = c_st_wait;
            c_st_wait:  if (ready || w_timeout) w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // Outputs decoded from state; the latched one-hot grant selects the line.
    always_comb begin
        w_strobe = '0;
        ack      = '0;
        busy     = (r_state != c_st_idle);
        if (r_state == c_st_issue) w_strobe = r_grant;
        if (r_state == c_st_done)  ack      = r_grant;
    end

    assign input_write    = w_strobe[c_idx_input_write];
    assign template_write = w_strobe[c_idx_template_write];
    assign ff_write       = w_strobe[c_idx_ff_write];
    assign input_read     = w_strobe[c_idx_input_read];
    assign template_read  = w_strobe[c_idx_template_read];
    assign ff_read        = w_strobe[c_idx_ff_read];

    // Operand latching, READY wait bookkeeping and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant         <= '0;
            r_win           <= '0;
            r_ptr           <= c_ptr_init;
            r_cnt           <= '0;
            r_ctrl_wdata_0  <= '0;
            r_ctrl_wdata_1  <= '0;
            r_template_bits <= '0;
            r_rd_data       <= '0;
            r_err           <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_req_any) begin
                        r_grant         <= w_arb_grant;
                        r_win           <= w_arb_idx;
                        r_ctrl_wdata_0  <= wr_data_0;
                        r_ctrl_wdata_1  <= wr_data_1;
                        r_template_bits <= template_sel;
                    end
                end
                c_st_issue: begin
                    r_cnt <= '0;
                end
                c_st_wait: begin
                    if (ready) begin
                        if (w_is_read) r_rd_data <= read_data_0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_w'(1);
                    if (template_change) r_template_bits[0] <= ~r_template_bits[0];
                end
                c_st_done: begin
                    r_ptr <= r_win;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_wdata_0  = r_ctrl_wdata_0;
    assign ctrl_wdata_1  = r_ctrl_wdata_1;
    assign template_bits = r_template_bits;
    assign rd_data       = r_rd_data;
    assign err           = r_err;

endmodule : bram_sched
`default_nettype wire
